// File: rtl/dff_sched_pkg.sv
// Shared types and helpers for the dff serial scheduler.
// The FSM state encoding and the error-counter width live here.
package dff_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int ERR_CNT_W = 16;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dff_sched_rr_arb.sv
// Combinational round-robin pick: first asserted request at or above ptr, wrapping.
// Zero latency; the caller owns and advances the pointer.
module dff_sched_rr_arb
  import dff_sched_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]                  req,
  input  logic [clog2_min1(NREQ)-1:0]      ptr,
  output logic [NREQ-1:0]                  grant,
  output logic [clog2_min1(NREQ)-1:0]      idx
);

  localparam int IW = clog2_min1(NREQ);

  logic found;
  int   j;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = (int'(ptr) + i) % NREQ;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/dff_serial_sched.sv
// Shares the 1-bit dff path among NREQ requesters: words go out LSB-first, come back rebuilt.
// Optional loopback compare of sent vs. captured word under DFF_SCHED_LOOPCHK_EN.
module dff_serial_sched
  import dff_sched_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREQ-1:0]               req_valid,
  input  logic [NREQ*WIDTH-1:0]         req_data,
  output logic [NREQ-1:0]               req_ready,
  output logic                          din,
  input  logic                          dout,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [clog2_min1(NREQ)-1:0]   rsp_id,
  output logic [WIDTH-1:0]              rsp_data,
  output logic                          busy
`ifdef DFF_SCHED_LOOPCHK_EN
  ,
  output logic                          err,
  output logic [ERR_CNT_W-1:0]          err_cnt
`endif
);

  localparam int IW = clog2_min1(NREQ);
  localparam int CW = clog2_min1(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  word;
  logic [WIDTH-1:0]  cap;
  logic [CW-1:0]     cnt;
  logic [IW-1:0]     gid;
  logic [IW-1:0]     ptr;
  logic [IW-1:0]     ptr_nxt;
  logic [NREQ-1:0]   grant;
  logic [IW-1:0]     gidx;

  dff_sched_rr_arb #(.NREQ(NREQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx)
  );

  assign ptr_nxt = (int'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req_valid)    state_nxt = SHIFT;
      SHIFT:   if (cnt == LAST)   state_nxt = DRAIN;
      DRAIN:                      state_nxt = RESP;
      RESP:    if (rsp_ready)     state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE) ? grant : '0;
    din       = (state == SHIFT) ? word[cnt] : 1'b0;
    rsp_valid = (state == RESP);
    busy      = (state != IDLE);
  end

  assign rsp_data = cap;
  assign rsp_id   = gid;

  // dout lags din by one cycle, so capture trails the shift index by one.
  always_ff @(posedge clk) begin
    if (rst) begin
      word <= '0;
      cap  <= '0;
      cnt  <= '0;
      gid  <= '0;
      ptr  <= '0;
    end else begin
      case (state)
        IDLE: if (|req_valid) begin
          word <= req_data[gidx*WIDTH +: WIDTH];
          gid  <= gidx;
          ptr  <= ptr_nxt;
          cnt  <= '0;
        end
        SHIFT: begin
          if (cnt != '0) cap[cnt - 1'b1] <= dout;
          cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
        DRAIN:   cap[WIDTH-1] <= dout;
        default: ;
      endcase
    end
  end

`ifdef DFF_SCHED_LOOPCHK_EN
  // Compare against the word as it will look on entry to RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else if (state == DRAIN && {dout, cap[WIDTH-2:0]} != word) begin
      err <= 1'b1;
      if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dff_serial_sched.sv
// Self-checking bench: directed scenarios plus randomized traffic against a transaction model.
// Loopback corruption scenario runs only when DFF_SCHED_LOOPCHK_EN is defined.
module tb_dff_serial_sched;

  localparam int N  = 2;
  localparam int W  = 8;
  localparam int NB = 3;
  localparam int WB = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]  req_ready;
  logic          din;
  logic          dout = 1'b0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [0:0]    rsp_id;
  logic [W-1:0]  rsp_data;
  logic          busy;
  logic          flip = 1'b0;

  logic [NB-1:0]    b_req_valid = '0;
  logic [NB*WB-1:0] b_req_data = '0;
  logic [NB-1:0]    b_req_ready;
  logic             b_din;
  logic             b_dout = 1'b0;
  logic             b_rsp_valid;
  logic             b_rsp_ready = 1'b1;
  logic [1:0]       b_rsp_id;
  logic [WB-1:0]    b_rsp_data;
  logic             b_busy;

`ifdef DFF_SCHED_LOOPCHK_EN
  logic        err, b_err;
  logic [15:0] err_cnt, b_err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Behavioural dff stand-ins; flip lets a test corrupt one returned bit.
  always @(posedge clk) begin
    dout   <= din ^ flip;
    b_dout <= b_din;
  end

  dff_serial_sched #(.NREQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .din(din), .dout(dout), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
`ifdef DFF_SCHED_LOOPCHK_EN
    , .err(err), .err_cnt(err_cnt)
`endif
  );

  dff_serial_sched #(.NREQ(NB), .WIDTH(WB)) dut_b (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_data(b_req_data),
    .req_ready(b_req_ready), .din(b_din), .dout(b_dout), .rsp_valid(b_rsp_valid),
    .rsp_ready(b_rsp_ready), .rsp_id(b_rsp_id), .rsp_data(b_rsp_data), .busy(b_busy)
`ifdef DFF_SCHED_LOOPCHK_EN
    , .err(b_err), .err_cnt(b_err_cnt)
`endif
  );

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++)
      if (v[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; flip = 1'b0; b_req_valid = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0;
    step();
    @(negedge clk);
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b want 00", req_ready); end
    checks++; if (din !== 1'b0) begin errors++; $display("FAIL reset_din got %b want 0", din); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id got %0d want 0", rsp_id); end
    checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL reset_rsp_data got %h want 00", rsp_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_single();
    logic [W-1:0] word;
    word = 8'hA5;
    do_reset();
    req_valid = 2'b01; req_data = {8'h00, word}; rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_grant got %b want 01", req_ready); end
    step();
    req_valid = '0;
    for (int t = 1; t <= W + 2; t++) begin
      @(negedge clk);
      checks++;
      if (din !== ((t <= W) ? word[t-1] : 1'b0)) begin
        errors++; $display("FAIL single_din t=%0d got %b want %b", t, din, (t <= W) ? word[t-1] : 1'b0);
      end
      checks++;
      if (rsp_valid !== (t == W + 2)) begin
        errors++; $display("FAIL single_rsp_valid t=%0d got %b want %b", t, rsp_valid, t == W + 2);
      end
      if (t < W + 2) step();
    end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL single_rsp_id got %0d want 0", rsp_id); end
    checks++; if (rsp_data !== word) begin errors++; $display("FAIL single_rsp_data got %h want %h", rsp_data, word); end
    step();
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_release got valid=%b busy=%b want 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    int gid[$], gcyc[$], rid[$];
    logic [W-1:0] rdat[$];
    do_reset();
    req_valid = 2'b11; req_data = {8'hC3, 8'h3C}; rsp_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin gid.push_back(req_ready == 2'b10 ? 1 : (req_ready == 2'b01 ? 0 : 9)); gcyc.push_back(c); end
      if (rsp_valid) begin rid.push_back(int'(rsp_id)); rdat.push_back(rsp_data); end
      step();
    end
    req_valid = '0;
    checks++;
    if (gid.size() < 5 || rid.size() < 4) begin
      errors++; $display("FAIL b2b_count got grants=%0d rsps=%0d want >=5 >=4", gid.size(), rid.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++; if (gid[k] != k % 2) begin errors++; $display("FAIL b2b_grant k=%0d got %0d want %0d", k, gid[k], k % 2); end
        checks++; if (gcyc[k+1] - gcyc[k] != W + 3) begin errors++; $display("FAIL b2b_spacing k=%0d got %0d want %0d", k, gcyc[k+1] - gcyc[k], W + 3); end
        checks++; if (rid[k] != k % 2) begin errors++; $display("FAIL b2b_rsp_id k=%0d got %0d want %0d", k, rid[k], k % 2); end
        checks++; if (rdat[k] !== ((k % 2) ? 8'hC3 : 8'h3C)) begin
          errors++; $display("FAIL b2b_rsp_data k=%0d got %h want %h", k, rdat[k], (k % 2) ? 8'hC3 : 8'h3C);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] d0;
    logic seen;
    d0 = 8'($urandom);
    do_reset();
    req_valid = 2'b11; req_data = {8'($urandom), d0}; rsp_ready = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
      else step();
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL stall_timeout got no rsp_valid want rsp_valid within 20 cycles");
    end else begin
      step();
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== d0) begin
          errors++; $display("FAIL stall_hold k=%0d got v=%b id=%0d d=%h want 1 0 %h", k, rsp_valid, rsp_id, rsp_data, d0);
        end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL stall_req_ready k=%0d got %b want 00", k, req_ready); end
        step();
      end
      rsp_ready = 1'b1;
      step();
      @(negedge clk);
      checks++; if (req_ready !== 2'b10 || rsp_valid !== 1'b0) begin
        errors++; $display("FAIL stall_next_grant got ready=%b valid=%b want 10 0", req_ready, rsp_valid);
      end
    end
    step();
    req_valid = '0;
  endtask

  task automatic test_reset_mid();
    logic quiet;
    do_reset();
    req_valid = 2'b01; req_data = {8'h00, 8'hA5}; rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rstmid_grant got %b want 01", req_ready); end
    step();
    req_valid = '0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || din !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 2'b00) begin
      errors++; $display("FAIL rstmid_ctrl got busy=%b din=%b v=%b rdy=%b want 0 0 0 00", busy, din, rsp_valid, req_ready);
    end
    checks++; if (rsp_id !== 1'b0 || rsp_data !== 8'h00) begin
      errors++; $display("FAIL rstmid_rsp got id=%0d d=%h want 0 00", rsp_id, rsp_data);
    end
    quiet = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step();
      @(negedge clk);
      if (rsp_valid) quiet = 1'b0;
    end
    checks++; if (!quiet) begin errors++; $display("FAIL rstmid_no_rsp got rsp_valid=1 want 0"); end
    step();
    req_valid = 2'b11;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rstmid_ptr got %b want 01", req_ready); end
    step();
    req_valid = '0;
  endtask

  task automatic test_boundary();
    do_reset();
    b_req_valid = 3'b100; b_req_data = {2'b10, 2'b00, 2'b00}; b_rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (b_req_ready !== 3'b100) begin errors++; $display("FAIL bnd_grant got %b want 100", b_req_ready); end
    step();
    b_req_valid = '0;
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      if (t == 1) begin checks++; if (b_din !== 1'b0) begin errors++; $display("FAIL bnd_din0 got %b want 0", b_din); end end
      if (t == 2) begin checks++; if (b_din !== 1'b1) begin errors++; $display("FAIL bnd_din1 got %b want 1", b_din); end end
      checks++; if (b_rsp_valid !== (t == 4)) begin errors++; $display("FAIL bnd_rsp_valid t=%0d got %b want %b", t, b_rsp_valid, t == 4); end
      if (t < 4) step();
    end
    checks++; if (b_rsp_id !== 2'd2 || b_rsp_data !== 2'b10) begin
      errors++; $display("FAIL bnd_rsp got id=%0d d=%b want 2 10", b_rsp_id, b_rsp_data);
    end
    step();
  endtask

  task automatic test_random();
    int mptr, mt, mid, w, granted;
    logic mbusy;
    logic [W-1:0] mword;
    logic [N-1:0] exp_rdy;
    logic exp_din, exp_rv;
    do_reset();
    mptr = 0; mbusy = 1'b0; mt = 0; mid = 0; mword = '0;
    req_valid = N'($urandom); req_data = 16'($urandom); rsp_ready = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      w = rr_pick(req_valid, mptr);
      exp_rdy = '0; exp_din = 1'b0; exp_rv = 1'b0;
      if (!mbusy) begin
        if (w >= 0) exp_rdy[w] = 1'b1;
      end else begin
        exp_rv  = (mt >= W + 2);
        exp_din = (mt <= W) ? mword[mt-1] : 1'b0;
      end
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rnd_req_ready c=%0d got %b want %b", c, req_ready, exp_rdy); end
      checks++; if (busy !== mbusy) begin errors++; $display("FAIL rnd_busy c=%0d got %b want %b", c, busy, mbusy); end
      checks++; if (din !== exp_din) begin errors++; $display("FAIL rnd_din c=%0d got %b want %b", c, din, exp_din); end
      checks++; if (rsp_valid !== exp_rv) begin errors++; $display("FAIL rnd_rsp_valid c=%0d got %b want %b", c, rsp_valid, exp_rv); end
      if (exp_rv) begin
        checks++; if (int'(rsp_id) != mid || rsp_data !== mword) begin
          errors++; $display("FAIL rnd_rsp c=%0d got id=%0d d=%h want %0d %h", c, rsp_id, rsp_data, mid, mword);
        end
      end
      @(posedge clk);
      granted = -1;
      if (!mbusy) begin
        if (w >= 0) begin
          mword = req_data[w*W +: W]; mid = w; mptr = (w + 1) % N;
          mbusy = 1'b1; mt = 1; granted = w;
        end
      end else if (mt >= W + 2 && rsp_ready) begin
        mbusy = 1'b0;
      end else begin
        mt++;
      end
      #1;
      for (int i = 0; i < N; i++) begin
        if (i == granted || !req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 2) == 0);
          req_data[i*W +: W] = 8'($urandom);
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    req_valid = '0;
  endtask

`ifdef DFF_SCHED_LOOPCHK_EN
  task automatic test_loopchk();
    logic seen;
    do_reset();
    req_valid = 2'b01; req_data = {8'h00, 8'hA5}; rsp_ready = 1'b1;
    step();
    req_valid = '0;
    step();
    step();
    flip = 1'b1;
    step();
    flip = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
      else step();
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL lchk_timeout got no rsp_valid want rsp_valid");
    end else begin
      checks++; if (rsp_data !== 8'hA1) begin errors++; $display("FAIL lchk_data got %h want a1", rsp_data); end
      checks++; if (err !== 1'b1 || err_cnt !== 16'd1) begin
        errors++; $display("FAIL lchk_err got err=%b cnt=%0d want 1 1", err, err_cnt);
      end
    end
    step();
    req_valid = 2'b01; req_data = {8'h00, 8'h5A};
    step();
    req_valid = '0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
      else step();
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL lchk_clean_timeout got no rsp_valid want rsp_valid");
    end else begin
      checks++; if (rsp_data !== 8'h5A || err !== 1'b1 || err_cnt !== 16'd1) begin
        errors++; $display("FAIL lchk_sticky got d=%h err=%b cnt=%0d want 5a 1 1", rsp_data, err, err_cnt);
      end
    end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_boundary();
    test_random();
`ifdef DFF_SCHED_LOOPCHK_EN
    test_loopchk();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
